// File: rtl/usertype_pkg.sv
// +----------------------------------------------------------------------+
// | Package : usertype                                                   |
// | Shared PSG types: player record, player id, cache FSM state encoding |
// | and the size of one player record in DRAM.                           |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package usertype;

  // One player record as stored in DRAM and in the cache.
  typedef logic [63:0] Player_Info;

  // Player identifier used by the PSG core.
  typedef logic [7:0] Player_id;

  // Bytes occupied by one Player_Info record in DRAM.
  localparam int unsigned PLAYER_BYTES = 8;

  // Player cache controller states.
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    WB_REQ     = 4'd1,
    WB_WAIT    = 4'd2,
    FILL_REQ   = 4'd3,
    FILL_WAIT  = 4'd4,
    RESP       = 4'd5,
    FLUSH_SCAN = 4'd6,
    FLUSH_WB   = 4'd7,
    FLUSH_WAIT = 4'd8
  } C_state;

endpackage

`default_nettype wire

// File: rtl/psg_cache_array.sv
// +----------------------------------------------------------------------+
// | Module  : psg_cache_array                                            |
// | Line storage for the player cache: valid, dirty, tag and record per  |
// | line. One combinational read port, one write port, synchronous clear |
// | of all valid and dirty bits.                                         |
// |                                                                      |
// | Ports:                                                               |
// |   clk          clock                                                 |
// |   clr_i        clear every valid and dirty bit at the next edge      |
// |   rd_idx_i     read index; rd_*_o reflect that line combinationally  |
// |   we_i         write enable; writes every field of line wr_idx_i     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module psg_cache_array
  import usertype::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic             rd_dirty_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output Player_Info       rd_data_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_valid_i,
  input  logic             wr_dirty_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  Player_Info       wr_data_i
);

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] dirty_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  Player_Info         data_q [ENTRIES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // Only the state bits need clearing; tag and data are meaningless
  // while valid is low.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/psg_player_cache.sv
// +----------------------------------------------------------------------+
// | Module  : psg_player_cache                                           |
// | Direct-mapped write-back cache of Player_Info records between the    |
// | PSG core and the DRAM bridge, with an explicit flush walk.           |
// |                                                                      |
// | Ports:                                                               |
// |   req_*       core request (valid/ready, write, id, write data)      |
// |   rsp_*       one-cycle response pulse with data and hit flag        |
// |   flush_req/flush_done   write back every dirty line                 |
// |   mem_rd_*    DRAM read address handshake and read data strobe       |
// |   mem_wr_*    DRAM write handshake and write-complete strobe         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module psg_player_cache
  import usertype::*;
#(
  parameter int unsigned       ENTRIES   = 16,
  parameter int unsigned       ADDR_W    = 17,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 17'h10000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  Player_id          req_id,
  input  Player_Info        req_wdata,
  output logic              rsp_valid,
  output Player_Info        rsp_data,
  output logic              rsp_hit,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_data_valid,
  input  Player_Info        mem_rd_data,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output Player_Info        mem_wr_data,
  input  logic              mem_wr_resp
);

  // Index/tag split of the 8-bit id. Either field may be zero-width
  // (ENTRIES = 1 or 256); the *_WS widths keep a 1-bit stand-in field that
  // is held at zero so the storage never needs zero-width vectors.
  localparam int unsigned IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 0;
  localparam int unsigned TAG_W  = 8 - IDX_W;
  localparam int unsigned IDX_WS = (IDX_W > 0) ? IDX_W : 1;
  localparam int unsigned TAG_WS = (TAG_W > 0) ? TAG_W : 1;
  localparam logic [IDX_WS-1:0] LAST_IDX = IDX_WS'(ENTRIES - 1);

  function automatic logic [IDX_WS-1:0] idx_of(input Player_id id);
    logic [IDX_WS-1:0] r;
    r = '0;
    if (IDX_W > 0) r = IDX_WS'(id);
    return r;
  endfunction

  function automatic logic [TAG_WS-1:0] tag_of(input Player_id id);
    logic [TAG_WS-1:0] r;
    r = '0;
    if (TAG_W > 0) r = TAG_WS'(id >> IDX_W);
    return r;
  endfunction

  // Rebuild the id of a resident line; zero-width fields read as zero.
  function automatic Player_id id_of(input logic [TAG_WS-1:0] tag,
                                     input logic [IDX_WS-1:0] idx);
    return (Player_id'(tag) << IDX_W) | Player_id'(idx);
  endfunction

  // Arithmetic is done at ADDR_W bits, which is the required truncation.
  function automatic logic [ADDR_W-1:0] addr_of(input Player_id id);
    logic [ADDR_W-1:0] off;
    off = ADDR_W'(id) * ADDR_W'(PLAYER_BYTES);
    return BASE_ADDR + off;
  endfunction

  C_state            state_q, state_d;
  logic              write_q, write_d;
  logic              hit_q, hit_d;
  Player_id          id_q, id_d;
  Player_Info        wdata_q, wdata_d;
  logic [IDX_WS-1:0] flush_idx_q, flush_idx_d;

  logic              rsp_valid_q, rsp_valid_d;
  Player_Info        rsp_data_q, rsp_data_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic              flush_done_q, flush_done_d;
  logic              mem_rd_valid_q, mem_rd_valid_d;
  logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic              mem_wr_valid_q, mem_wr_valid_d;
  logic [ADDR_W-1:0] mem_wr_addr_q, mem_wr_addr_d;
  Player_Info        mem_wr_data_q, mem_wr_data_d;

  logic [IDX_WS-1:0] arr_idx;
  logic              arr_valid, arr_dirty;
  logic [TAG_WS-1:0] arr_tag;
  Player_Info        arr_data;
  logic              arr_we;
  logic              arr_wr_dirty;
  logic [TAG_WS-1:0] arr_wr_tag;
  Player_Info        arr_wr_data;

  // Every array write targets the line currently being read, so one
  // index serves both ports.
  psg_cache_array #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_WS),
    .TAG_W   (TAG_WS)
  ) u_array (
    .clk        (clk),
    .clr_i      (~rst_n),
    .rd_idx_i   (arr_idx),
    .rd_valid_o (arr_valid),
    .rd_dirty_o (arr_dirty),
    .rd_tag_o   (arr_tag),
    .rd_data_o  (arr_data),
    .we_i       (arr_we),
    .wr_idx_i   (arr_idx),
    .wr_valid_i (1'b1),
    .wr_dirty_i (arr_wr_dirty),
    .wr_tag_i   (arr_wr_tag),
    .wr_data_i  (arr_wr_data)
  );

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    hit_d          = hit_q;
    id_d           = id_q;
    wdata_d        = wdata_q;
    flush_idx_d    = flush_idx_q;
    rsp_valid_d    = 1'b0;
    rsp_data_d     = rsp_data_q;
    rsp_hit_d      = rsp_hit_q;
    flush_done_d   = 1'b0;
    mem_rd_valid_d = mem_rd_valid_q;
    mem_rd_addr_d  = mem_rd_addr_q;
    mem_wr_valid_d = mem_wr_valid_q;
    mem_wr_addr_d  = mem_wr_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    arr_we         = 1'b0;
    arr_wr_dirty   = 1'b0;
    arr_wr_tag     = arr_tag;
    arr_wr_data    = arr_data;

    // The lookup happens against the incoming id in IDLE; afterwards the
    // latched id (or the flush cursor) selects the line.
    case (state_q)
      IDLE:                              arr_idx = idx_of(req_id);
      FLUSH_SCAN, FLUSH_WB, FLUSH_WAIT:  arr_idx = flush_idx_q;
      default:                           arr_idx = idx_of(id_q);
    endcase

    case (state_q)
      IDLE: begin
        if (flush_req) begin
          flush_idx_d = '0;
          state_d     = FLUSH_SCAN;
        end else if (req_valid) begin
          write_d = req_write;
          id_d    = req_id;
          wdata_d = req_wdata;
          hit_d   = arr_valid && (arr_tag == tag_of(req_id));
          if (arr_valid && (arr_tag == tag_of(req_id))) begin
            state_d = RESP;
          end else if (arr_valid && arr_dirty) begin
            mem_wr_valid_d = 1'b1;
            mem_wr_addr_d  = addr_of(id_of(arr_tag, idx_of(req_id)));
            mem_wr_data_d  = arr_data;
            state_d        = WB_REQ;
          end else if (req_write) begin
            // Whole-record write: nothing to fetch.
            state_d = RESP;
          end else begin
            mem_rd_valid_d = 1'b1;
            mem_rd_addr_d  = addr_of(req_id);
            state_d        = FILL_REQ;
          end
        end
      end

      WB_REQ: begin
        if (mem_wr_ready) begin
          mem_wr_valid_d = 1'b0;
          state_d        = WB_WAIT;
        end
      end

      WB_WAIT: begin
        if (mem_wr_resp) begin
          if (write_q) begin
            state_d = RESP;
          end else begin
            mem_rd_valid_d = 1'b1;
            mem_rd_addr_d  = addr_of(id_q);
            state_d        = FILL_REQ;
          end
        end
      end

      FILL_REQ: begin
        if (mem_rd_ready) begin
          mem_rd_valid_d = 1'b0;
          state_d        = FILL_WAIT;
        end
      end

      FILL_WAIT: begin
        if (mem_rd_data_valid) begin
          arr_we       = 1'b1;
          arr_wr_dirty = 1'b0;
          arr_wr_tag   = tag_of(id_q);
          arr_wr_data  = mem_rd_data;
          state_d      = RESP;
        end
      end

      RESP: begin
        // A read returns the line (already filled on a miss); a write
        // installs its record here for hits and misses alike.
        rsp_valid_d = 1'b1;
        rsp_hit_d   = hit_q;
        rsp_data_d  = write_q ? wdata_q : arr_data;
        if (write_q) begin
          arr_we       = 1'b1;
          arr_wr_dirty = 1'b1;
          arr_wr_tag   = tag_of(id_q);
          arr_wr_data  = wdata_q;
        end
        state_d = IDLE;
      end

      FLUSH_SCAN: begin
        if (arr_valid && arr_dirty) begin
          mem_wr_valid_d = 1'b1;
          mem_wr_addr_d  = addr_of(id_of(arr_tag, flush_idx_q));
          mem_wr_data_d  = arr_data;
          state_d        = FLUSH_WB;
        end else if (flush_idx_q == LAST_IDX) begin
          flush_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          flush_idx_d = flush_idx_q + IDX_WS'(1);
        end
      end

      FLUSH_WB: begin
        if (mem_wr_ready) begin
          mem_wr_valid_d = 1'b0;
          state_d        = FLUSH_WAIT;
        end
      end

      FLUSH_WAIT: begin
        if (mem_wr_resp) begin
          // Rewrite the line with only the dirty bit cleared.
          arr_we       = 1'b1;
          arr_wr_dirty = 1'b0;
          if (flush_idx_q == LAST_IDX) begin
            flush_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            flush_idx_d = flush_idx_q + IDX_WS'(1);
            state_d     = FLUSH_SCAN;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      write_q        <= 1'b0;
      hit_q          <= 1'b0;
      id_q           <= '0;
      wdata_q        <= '0;
      flush_idx_q    <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_hit_q      <= 1'b0;
      flush_done_q   <= 1'b0;
      mem_rd_valid_q <= 1'b0;
      mem_rd_addr_q  <= '0;
      mem_wr_valid_q <= 1'b0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      write_q        <= write_d;
      hit_q          <= hit_d;
      id_q           <= id_d;
      wdata_q        <= wdata_d;
      flush_idx_q    <= flush_idx_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_hit_q      <= rsp_hit_d;
      flush_done_q   <= flush_done_d;
      mem_rd_valid_q <= mem_rd_valid_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      mem_wr_addr_q  <= mem_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_hit      = rsp_hit_q;
  assign flush_done   = flush_done_q;
  assign mem_rd_valid = mem_rd_valid_q;
  assign mem_rd_addr  = mem_rd_addr_q;
  assign mem_wr_valid = mem_wr_valid_q;
  assign mem_wr_addr  = mem_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;

endmodule

`default_nettype wire

// File: doc/psg_player_cache.md
# psg_player_cache

Parametrised, direct-mapped, write-back cache of `Player_Info` records between the PSG core FSM and the DRAM bridge. The core issues whole-record reads or writes by `Player_id`. Hits complete in one cycle without DRAM traffic. Misses evict a dirty victim and fill from DRAM through separate read and write handshake channels. An explicit flush writes every dirty line back before the core ends a pattern.

## Interface
Parameters:
- `ENTRIES`, 16: number of cache lines; power of two, 1..256.
- `ADDR_W`, 17: DRAM byte-address width.
- `BASE_ADDR`, 17'h10000: DRAM address of player 0.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  1  core request strobe.
- `req_ready`  out  1  cache can accept a request.
- `req_write`  in  1  1 = write the whole record, 0 = read.
- `req_id`  in  8  `Player_id`.
- `req_wdata`  in  64  `Player_Info` to write.
- `rsp_valid`  out  1  one-cycle response pulse; no backpressure.
- `rsp_data`  out  64  record read, or echo of the record written.
- `rsp_hit`  out  1  request hit; qualified by `rsp_valid`.
- `flush_req`  in  1  start flush; sampled only in IDLE.
- `flush_done`  out  1  one-cycle pulse when the flush completes.
- `mem_rd_valid` / `mem_rd_ready`  out / in  1  DRAM read-address handshake.
- `mem_rd_addr`  out  `ADDR_W`  read address.
- `mem_rd_data_valid`  in  1  read data strobe.
- `mem_rd_data`  in  64  read data.
- `mem_wr_valid` / `mem_wr_ready`  out / in  1  DRAM write handshake.
- `mem_wr_addr`  out  `ADDR_W`  write address.
- `mem_wr_data`  out  64  write data.
- `mem_wr_resp`  in  1  write-complete strobe.

## Operation
- Index = `req_id[log2(ENTRIES)-1:0]`; tag = the remaining id bits. Each line holds valid, dirty, tag and a 64-bit record.
- DRAM address = `BASE_ADDR + {req_id, 3'b000}`, truncated to `ADDR_W` bits.
- Read hit: return the line data, `rsp_hit` = 1.
- Write hit: store `req_wdata`, set dirty, echo the data, `rsp_hit` = 1.
- Read miss:
  - If the victim is valid and dirty, write it back first.
  - Then fill from DRAM and set valid, clear dirty, update the tag.
  - Respond with the fill data, `rsp_hit` = 0.
- Write miss: write back a dirty victim if there is one, then install `req_wdata` directly with dirty = 1. There is no fill, because the write covers the whole record.
- Flush:
  - Walk index 0..ENTRIES-1 and write back each valid dirty line, then clear its dirty bit.
  - Clean and invalid lines cost one cycle each.
  - Pulse `flush_done`; the lines stay valid.
- FSM states: IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP, FLUSH_SCAN, FLUSH_WB, FLUSH_WAIT.
  - IDLE → RESP on a hit.
  - IDLE → WB_REQ on a dirty miss.
  - IDLE → FILL_REQ on a clean read miss.
  - IDLE → RESP on a clean write miss.
  - WB_REQ → WB_WAIT on `mem_wr_ready`.
  - WB_WAIT → FILL_REQ on `mem_wr_resp` for a read, or → RESP for a write.
  - FILL_REQ → FILL_WAIT on `mem_rd_ready`.
  - FILL_WAIT → RESP on `mem_rd_data_valid`.
  - RESP → IDLE.
  - FLUSH_SCAN, FLUSH_WB and FLUSH_WAIT loop over all indices, then → IDLE with `flush_done`.
- In IDLE, `flush_req` has priority over `req_valid`. During the flush `req_ready` = 0.

## Timing
- Reset values: `req_ready` = 1. All other outputs = 0, including all address and data buses. All valid and dirty bits are cleared.
- `req_ready` is high only in IDLE. A request is accepted at the edge where `req_valid && req_ready`, and its fields are latched at that edge.
- Hit: accepted at edge k, `rsp_valid` high for the cycle after edge k+1.
- Clean read miss:
  - `mem_rd_valid` rises the cycle after acceptance and holds, with a stable address, until `mem_rd_ready`.
  - `rsp_valid` is asserted the cycle after `mem_rd_data_valid`.
- Dirty miss: the full write-back (`mem_wr_valid` held until `mem_wr_ready`, then wait for `mem_wr_resp`) completes before `mem_rd_valid` is raised. The two DRAM channels are never active together.
- The earliest next request is accepted the cycle `rsp_valid` is high.
- `rsp_data` and `rsp_hit` are valid only while `rsp_valid` = 1 and hold their value otherwise.
- Reset mid-transaction clears the FSM, all lines and both DRAM valids. The DRAM model is reset in the same cycle. Pending data is lost by definition.
- `ENTRIES` = 256 gives a zero-width tag; every valid line hits on index alone.

## Structure
- Add to the `usertype` package: the enum `C_state` for the nine FSM states, and the constant `PLAYER_BYTES` = 8. Reuse `Player_Info` and `Player_id`.
- Sub-module `psg_cache_array`: line storage (valid, dirty, tag, data) with one combinational read port and one write port, plus a synchronous clear of valid and dirty.

## Test plan
- Reset, read id 8'h05 with DRAM returning 64'hA5A5_0000_1111_2222 → `mem_rd_addr` = 17'h10028, `rsp_data` = that value, `rsp_hit` = 0. A repeat read → `rsp_hit` = 1 one cycle after acceptance, with no DRAM traffic.
- Write id 8'h05 with 64'h1 (hit), then read id 8'h15 (same index, `ENTRIES` = 16) → write-back to 17'h10028 with data 64'h1 first, then a fill read at 17'h100A8.
- Write miss to clean index 3, id 8'h03 → no DRAM read, `rsp_valid` on the next cycle, line dirty.
- Dirty ids 8'h01 and 8'h0E, then `flush_req` → exactly two writes in index order (17'h10008, 17'h10070), one `flush_done`, and a re-flush produces zero writes.
- `mem_rd_ready` held low for 10 cycles → `mem_rd_valid` and `mem_rd_addr` stay stable and `req_ready` = 0 throughout.
- `rst_n` = 0 during FILL_WAIT → the next cycle every output is at its reset value, and re-reading the same id misses.
